// File: rtl/multi_channel_fifo.sv
// ============================================================================
// Module      : multi_channel_fifo
// Description : CHANNELS independent circular-buffer FIFOs sharing one clock.
//               Optional sticky overflow/underflow flags: MCFIFO_ERR_FLAGS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multi_channel_fifo #(
  parameter int D_WIDTH  = 6,
  parameter int CHANNELS = 2,
  parameter int DEPTH    = 4
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [CHANNELS*D_WIDTH-1:0]           up_data_i,
  input  logic [CHANNELS-1:0]                   push_i,
  input  logic [CHANNELS-1:0]                   pop_i,
  output logic [CHANNELS*D_WIDTH-1:0]           down_data_o,
  output logic [CHANNELS-1:0]                   full_o,
  output logic [CHANNELS-1:0]                   empty_o,
  output logic [CHANNELS*($clog2(DEPTH)+1)-1:0] count_o,
  input  logic                                  err_clr_i,
  output logic [CHANNELS-1:0]                   overflow_o,
  output logic [CHANNELS-1:0]                   underflow_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [D_WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]      wr_ptr_q;
    logic [PW-1:0]      rd_ptr_q;
    logic [CW-1:0]      count_q;
    logic [CW-1:0]      count_d;
    logic               w_full;
    logic               w_empty;
    logic               w_push_acc;
    logic               w_pop_acc;

    assign w_full     = (count_q == CW'(DEPTH));
    assign w_empty    = (count_q == '0);
    // A simultaneous pop frees the slot, so a push on full is still taken.
    assign w_push_acc = push_i[i] & (~w_full | pop_i[i]);
    assign w_pop_acc  = pop_i[i] & ~w_empty;

    always_comb begin
      count_d = count_q;
      if (w_push_acc && !w_pop_acc) begin
        count_d = count_q + CW'(1);
      end else if (w_pop_acc && !w_push_acc) begin
        count_d = count_q - CW'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (w_push_acc) begin
        mem_q[wr_ptr_q] <= up_data_i[i*D_WIDTH +: D_WIDTH];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (w_push_acc) begin
          wr_ptr_q <= wr_ptr_q + PW'(1);
        end
        if (w_pop_acc) begin
          rd_ptr_q <= rd_ptr_q + PW'(1);
        end
        count_q <= count_d;
      end
    end

    assign full_o[i]                      = w_full;
    assign empty_o[i]                     = w_empty;
    assign count_o[i*CW +: CW]            = count_q;
    assign down_data_o[i*D_WIDTH +: D_WIDTH] = w_empty ? '0 : mem_q[rd_ptr_q];

`ifdef MCFIFO_ERR_FLAGS_EN
    logic overflow_q;
    logic underflow_q;
    logic overflow_d;
    logic underflow_d;

    // A new error in the clearing cycle keeps the flag set.
    assign overflow_d  = (overflow_q & ~err_clr_i) | (push_i[i] & w_full & ~pop_i[i]);
    assign underflow_d = (underflow_q & ~err_clr_i) | (pop_i[i] & w_empty);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        overflow_q  <= 1'b0;
        underflow_q <= 1'b0;
      end else begin
        overflow_q  <= overflow_d;
        underflow_q <= underflow_d;
      end
    end

    assign overflow_o[i]  = overflow_q;
    assign underflow_o[i] = underflow_q;
`else
    assign overflow_o[i]  = 1'b0;
    assign underflow_o[i] = 1'b0;
`endif
  end

`ifndef MCFIFO_ERR_FLAGS_EN
  logic w_unused_err_clr;
  assign w_unused_err_clr = err_clr_i;
`endif

endmodule

`default_nettype wire

// File: tb/tb_multi_channel_fifo.sv
// ============================================================================
// Module      : tb_multi_channel_fifo
// Description : Directed scoreboard bench for multi_channel_fifo (2 ch x 4 x 6b).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multi_channel_fifo;

  localparam int D_WIDTH  = 6;
  localparam int CHANNELS = 2;
  localparam int DEPTH    = 4;
  localparam int CW       = $clog2(DEPTH) + 1;
`ifdef MCFIFO_ERR_FLAGS_EN
  localparam bit FLAGS_EN = 1'b1;
`else
  localparam bit FLAGS_EN = 1'b0;
`endif

  logic                          clk;
  logic                          rst_n;
  logic [CHANNELS*D_WIDTH-1:0]   up_data;
  logic [CHANNELS-1:0]           push;
  logic [CHANNELS-1:0]           pop;
  logic [CHANNELS*D_WIDTH-1:0]   down_data;
  logic [CHANNELS-1:0]           full;
  logic [CHANNELS-1:0]           empty;
  logic [CHANNELS*CW-1:0]        count;
  logic                          err_clr;
  logic [CHANNELS-1:0]           overflow;
  logic [CHANNELS-1:0]           underflow;

  int vectors;
  int miscompares;

  logic [D_WIDTH-1:0] sbq0 [$];
  logic [D_WIDTH-1:0] sbq1 [$];
  logic [CHANNELS-1:0] ovf_m;
  logic [CHANNELS-1:0] unf_m;

  multi_channel_fifo #(
    .D_WIDTH  (D_WIDTH),
    .CHANNELS (CHANNELS),
    .DEPTH    (DEPTH)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .up_data_i   (up_data),
    .push_i      (push),
    .pop_i       (pop),
    .down_data_o (down_data),
    .full_o      (full),
    .empty_o     (empty),
    .count_o     (count),
    .err_clr_i   (err_clr),
    .overflow_o  (overflow),
    .underflow_o (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int c = 0; c < CHANNELS; c++) begin
      int n;
      logic [D_WIDTH-1:0] head;
      n    = (c == 0) ? sbq0.size() : sbq1.size();
      head = '0;
      if (n > 0) head = (c == 0) ? sbq0[0] : sbq1[0];
      chk($sformatf("count[%0d]", c), 32'(count[c*CW +: CW]), 32'(n));
      chk($sformatf("full[%0d]", c), 32'(full[c]), 32'(n == DEPTH));
      chk($sformatf("empty[%0d]", c), 32'(empty[c]), 32'(n == 0));
      chk($sformatf("down_data[%0d]", c), 32'(down_data[c*D_WIDTH +: D_WIDTH]), 32'(head));
      chk($sformatf("overflow[%0d]", c), 32'(overflow[c]), 32'(FLAGS_EN & ovf_m[c]));
      chk($sformatf("underflow[%0d]", c), 32'(underflow[c]), 32'(FLAGS_EN & unf_m[c]));
    end
  endtask

  // Drive one cycle, update the scoreboard, then check after the edge.
  task automatic step(input logic [1:0] pu, input logic [1:0] po,
                      input logic [D_WIDTH-1:0] d0, input logic [D_WIDTH-1:0] d1,
                      input logic clr);
    push    = pu;
    pop     = po;
    up_data = {d1, d0};
    err_clr = clr;
    for (int c = 0; c < CHANNELS; c++) begin
      int n;
      bit pacc;
      bit oacc;
      logic [D_WIDTH-1:0] h;
      n    = (c == 0) ? sbq0.size() : sbq1.size();
      pacc = pu[c] && ((n < DEPTH) || po[c]);
      oacc = po[c] && (n > 0);
      if (oacc) begin
        h = (c == 0) ? sbq0.pop_front() : sbq1.pop_front();
        chk($sformatf("pop_data[%0d]", c), 32'(down_data[c*D_WIDTH +: D_WIDTH]), 32'(h));
      end
      if (pacc) begin
        if (c == 0) sbq0.push_back(d0);
        else        sbq1.push_back(d1);
      end
      ovf_m[c] = (ovf_m[c] & ~clr) | (pu[c] & (n == DEPTH) & ~po[c]);
      unf_m[c] = (unf_m[c] & ~clr) | (po[c] & (n == 0));
    end
    @(posedge clk);
    #1;
    push    = '0;
    pop     = '0;
    err_clr = 1'b0;
    check_all();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    ovf_m       = '0;
    unf_m       = '0;
    rst_n       = 1'b1;
    push        = '0;
    pop         = '0;
    up_data     = '0;
    err_clr     = 1'b0;

    #2 rst_n = 1'b0;
    #1 check_all();
    @(negedge clk);
    rst_n = 1'b1;
    #1 check_all();

    // Fill channel 0; head must be the first value written.
    step(2'b01, 2'b00, 6'h11, 6'h00, 1'b0);
    step(2'b01, 2'b00, 6'h22, 6'h00, 1'b0);
    step(2'b01, 2'b00, 6'h33, 6'h00, 1'b0);
    step(2'b01, 2'b00, 6'h34, 6'h00, 1'b0);

    // Dropped push on full, then drain in order.
    step(2'b01, 2'b00, 6'h3F, 6'h00, 1'b0);
    for (int k = 0; k < 4; k++) step(2'b00, 2'b01, 6'h00, 6'h00, 1'b0);

    // Refill, then simultaneous push+pop on full through pointer wrap.
    step(2'b01, 2'b00, 6'h11, 6'h00, 1'b0);
    step(2'b01, 2'b00, 6'h22, 6'h00, 1'b0);
    step(2'b01, 2'b00, 6'h33, 6'h00, 1'b0);
    step(2'b01, 2'b00, 6'h34, 6'h00, 1'b0);
    step(2'b01, 2'b01, 6'h05, 6'h00, 1'b0);
    for (int k = 0; k < 10; k++)
      step(2'b01, 2'b01, 6'($urandom_range(0, 63)), 6'h00, 1'b0);

    // Channel 1: push+pop on empty, error clear, clear with coincident error.
    step(2'b10, 2'b10, 6'h00, 6'h2A, 1'b0);
    step(2'b00, 2'b00, 6'h00, 6'h00, 1'b1);
    step(2'b00, 2'b10, 6'h00, 6'h00, 1'b0);
    step(2'b00, 2'b10, 6'h00, 6'h00, 1'b1);

    // Three entries per channel, then asynchronous reset between edges.
    step(2'b00, 2'b01, 6'h00, 6'h00, 1'b0);
    step(2'b10, 2'b00, 6'h00, 6'h01, 1'b0);
    step(2'b10, 2'b00, 6'h00, 6'h02, 1'b0);
    step(2'b10, 2'b00, 6'h00, 6'h03, 1'b0);
    #2 rst_n = 1'b0;
    sbq0.delete();
    sbq1.delete();
    ovf_m = '0;
    unf_m = '0;
    #1 check_all();
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("empty_after_release", 32'(empty), 32'(2'b11));

    // First edge after release accepts pushes.
    step(2'b11, 2'b00, 6'h15, 6'h2B, 1'b0);
    step(2'b00, 2'b11, 6'h00, 6'h00, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/multi_channel_fifo.md
MULTI_CHANNEL_FIFO -- requirements
Module: multi_channel_fifo

Interface
REQ-001 The block SHALL have parameter D_WIDTH, default 6, giving data width per channel in bits.
REQ-002 The block SHALL have parameter CHANNELS, default 2, giving the number of independent FIFO channels (legal range 1..16).
REQ-003 The block SHALL have parameter DEPTH, default 4, giving entries per channel (power of two, legal range 2..256); CW = $clog2(DEPTH)+1.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 up_data  input  CHANNELS*D_WIDTH  write data; channel i occupies bits [i*D_WIDTH +: D_WIDTH].
REQ-007 push  input  CHANNELS  per-channel write request.
REQ-008 pop  input  CHANNELS  per-channel read request.
REQ-009 down_data  output  CHANNELS*D_WIDTH  per-channel head-of-queue data, same packing as up_data.
REQ-010 full  output  CHANNELS  per-channel count == DEPTH.
REQ-011 empty  output  CHANNELS  per-channel count == 0.
REQ-012 count  output  CHANNELS*CW  per-channel occupancy, channel i at [i*CW +: CW].
REQ-013 err_clr  input  1  clears all sticky error flags.
REQ-014 overflow  output  CHANNELS  sticky per-channel push-while-full flag.
REQ-015 underflow  output  CHANNELS  sticky per-channel pop-while-empty flag.

Function
REQ-016 Channels SHALL be fully independent; no event on channel i SHALL affect state of channel j.
REQ-017 Each channel SHALL be a circular buffer with rd/wr pointers of $clog2(DEPTH) bits wrapping DEPTH-1 -> 0 and a CW-bit count.
REQ-018 Push accepted when !full or (full and pop same cycle); data written at wr_ptr, wr_ptr+1.
REQ-019 Pop accepted when !empty; rd_ptr+1; pop on empty ignored with no pointer change.
REQ-020 Count: +1 on accepted push only, -1 on accepted pop only, unchanged on both or neither.
REQ-021 Push on full without pop SHALL be dropped; stored data and count unchanged.
REQ-022 Push+pop on empty: push accepted, pop ignored; count becomes 1.
REQ-023 down_data SHALL be combinational from registered storage at rd_ptr, i.e. first visible in the cycle after the accepting edge (zero-cycle fall-through forbidden); SHALL read 0 when empty.
REQ-024 full, empty, count SHALL be derived from registered state only, no combinational path from push/pop.
REQ-025 overflow[i] SHALL set on the edge of a dropped push (REQ-021); underflow[i] on the edge of an ignored pop on empty (including REQ-022).
REQ-026 err_clr SHALL clear all flags on the edge; a same-cycle new error SHALL win (flag remains 1).

Reset
REQ-027 On rst_n low, asynchronously: all pointers and counts 0, empty all 1, full all 0, count all 0, down_data all 0, overflow/underflow all 0.
REQ-028 Storage contents SHALL NOT require reset; reset mid-operation discards all queued data in all channels.
REQ-029 Reset deassertion SHALL be taken synchronously downstream; first push accepted on the first rising edge with rst_n high.

Configuration
REQ-030 Macro MCFIFO_ERR_FLAGS_EN defined: overflow/underflow/err_clr behave per REQ-025..026.
REQ-031 Macro MCFIFO_ERR_FLAGS_EN undefined: ports SHALL remain present, overflow and underflow tied to 0, err_clr ignored, no flag registers instantiated; all other behaviour identical.

Verification (D_WIDTH=6, CHANNELS=2, DEPTH=4, macro defined unless stated)
REQ-032 Push ch0 0x11,0x22,0x33,0x34 on 4 cycles -> full[0]=1, count ch0=4, down_data ch0=0x11; ch1 empty=1, count=0.
REQ-033 From full ch0, push 0x3F without pop -> overflow[0]=1, count 4, data unchanged; then pop x4 -> 0x11,0x22,0x33,0x34 in order, empty[0]=1, down_data ch0=0.
REQ-034 Full ch0, push 0x05 + pop same cycle -> count stays 4, head becomes 0x22, tail 0x05, overflow unchanged; continue 10 push+pop cycles -> ordering correct across pointer wrap.
REQ-035 Empty ch1, push 0x2A + pop same cycle -> count=1, down_data ch1=0x2A next cycle, underflow[1]=1; err_clr pulse -> underflow[1]=0; err_clr with coincident pop-on-empty -> underflow stays 1.
REQ-036 With 3 entries in each channel, drive rst_n low between clock edges -> all outputs reach reset values immediately without a clock edge; after release, empty=2'b11.
REQ-037 Repeat REQ-033 with MCFIFO_ERR_FLAGS_EN undefined -> overflow=0, underflow=0 throughout, data ordering identical.
